// File: rtl/vram_arbiter.sv
// VRAM arbiter: shares one single-port sync RAM between a display
// fetcher and an Avalon-MM slave, with a bounded display streak.
module vram_arbiter #(
  parameter int ADDR_W     = 10,
  parameter int DEPTH      = 600,
  parameter int STARVE_MAX = 3
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              AVL_CS,
  input  logic              AVL_READ,
  input  logic              AVL_WRITE,
  input  logic [3:0]        AVL_BYTE_EN,
  input  logic [ADDR_W-1:0] AVL_ADDR,
  input  logic [31:0]       AVL_WRITEDATA,
  output logic [31:0]       AVL_READDATA,
  output logic              AVL_WAITREQUEST,
  input  logic              DISP_REQ,
  input  logic [ADDR_W-1:0] DISP_ADDR,
  output logic [31:0]       DISP_DATA,
  output logic              DISP_VALID,
  output logic [ADDR_W-1:0] RAM_ADDR,
  output logic              RAM_WE,
  output logic [3:0]        RAM_BE,
  output logic [31:0]       RAM_WDATA,
  input  logic [31:0]       RAM_RDATA
);

  localparam int SC = $clog2(STARVE_MAX + 1);
  localparam int SW = (SC < 2) ? 2 : SC;
  localparam logic [SW-1:0] SMAX = SW'(STARVE_MAX);
  localparam logic [ADDR_W:0] DEPTH_W = (ADDR_W + 1)'(DEPTH);

  typedef enum logic [2:0] {
    IDLE, DRD, DCAP, ARD, ACAP, AWR
  } state_t;

  state_t            state, state_n;
  logic [SW-1:0]     streak, streak_n;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       wdata_q;
  logic [3:0]        be_q;

  logic d_pend, a_pend, decide, starved;
  logic grant_d, grant_a, in_range, live;

  assign d_pend   = DISP_REQ;
  assign a_pend   = AVL_CS & (AVL_READ | AVL_WRITE);
  assign decide   = (state == IDLE) | (state == DCAP) |
                    (state == ACAP) | (state == AWR);
  assign starved  = (streak == SMAX);
  assign grant_d  = decide & d_pend & ~(a_pend & starved);
  assign grant_a  = decide & a_pend & ~grant_d;
  assign in_range = ({1'b0, addr_q} < DEPTH_W);
  assign live     = ~RESET;

  always_comb begin
    state_n  = state;
    streak_n = streak;
    unique case (state)
      DRD:     state_n = DCAP;
      ARD:     state_n = ACAP;
      default: begin
        if (grant_d)      state_n = DRD;
        else if (grant_a) state_n = AVL_WRITE ? AWR : ARD;
        else              state_n = IDLE;
      end
    endcase
    // Streak only counts display wins that actually made Avalon wait
    if (!a_pend || grant_a)      streak_n = '0;
    else if (grant_d && !starved) streak_n = streak + 1'b1;
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state   <= IDLE;
      streak  <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      be_q    <= '0;
    end else begin
      state  <= state_n;
      streak <= streak_n;
      if (grant_d) addr_q <= DISP_ADDR;
      if (grant_a) begin
        addr_q  <= AVL_ADDR;
        wdata_q <= AVL_WRITEDATA;
        be_q    <= AVL_BYTE_EN;
      end
    end
  end

  // Gate strobes with reset so an aborted access leaves no trace
  assign RAM_ADDR        = addr_q;
  assign RAM_BE          = be_q;
  assign RAM_WDATA       = wdata_q;
  assign RAM_WE          = live & (state == AWR) & in_range;
  assign DISP_VALID      = live & (state == DCAP);
  assign DISP_DATA       = DISP_VALID ? RAM_RDATA : 32'h0;
  assign AVL_WAITREQUEST = ~(live & ((state == ACAP) | (state == AWR)));
  assign AVL_READDATA    = (live & (state == ACAP) & in_range) ?
                           RAM_RDATA : 32'h0;

endmodule
